// File: rtl/axi4_burst_master.sv
// AXI4 burst master: one command (addr, beats, FIXED/INCR, R/W) becomes legal AXI4 bursts fed by/feeding streams.
// Optional perf counters (perf_beats/perf_cycles) are built when AXI4_BURST_MASTER_PERF_EN is defined.
module axi4_burst_master #(
  parameter int ID_WIDTH       = 1,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MAX_BURST      = 256,
  parameter int CMD_LEN_WIDTH  = 24
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CMD_LEN_WIDTH-1:0]    cmd_len,
  input  logic                        cmd_burst,
  input  logic [AXI_DATA_WIDTH-1:0]   wr_tdata,
  input  logic                        wr_tvalid,
  output logic                        wr_tready,
  output logic [AXI_DATA_WIDTH-1:0]   rd_tdata,
  output logic                        rd_tvalid,
  input  logic                        rd_tready,
  output logic                        rd_tlast,
  output logic                        done,
  output logic [1:0]                  done_resp,
  output logic                        done_misalign,
`ifdef AXI4_BURST_MASTER_PERF_EN
  output logic [31:0]                 perf_beats,
  output logic [31:0]                 perf_cycles,
`endif
  output logic [ID_WIDTH-1:0]         axi4m_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi4m_awaddr,
  output logic [7:0]                  axi4m_awlen,
  output logic [2:0]                  axi4m_awsize,
  output logic [1:0]                  axi4m_awburst,
  output logic                        axi4m_awlock,
  output logic [3:0]                  axi4m_awcache,
  output logic [2:0]                  axi4m_awprot,
  output logic [3:0]                  axi4m_awqos,
  output logic [3:0]                  axi4m_awregion,
  output logic                        axi4m_awvalid,
  input  logic                        axi4m_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi4m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi4m_wstrb,
  output logic                        axi4m_wlast,
  output logic                        axi4m_wvalid,
  input  logic                        axi4m_wready,
  input  logic [1:0]                  axi4m_bresp,
  input  logic                        axi4m_bvalid,
  output logic                        axi4m_bready,
  output logic [ID_WIDTH-1:0]         axi4m_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   axi4m_araddr,
  output logic [7:0]                  axi4m_arlen,
  output logic [2:0]                  axi4m_arsize,
  output logic [1:0]                  axi4m_arburst,
  output logic                        axi4m_arlock,
  output logic [3:0]                  axi4m_arcache,
  output logic [2:0]                  axi4m_arprot,
  output logic [3:0]                  axi4m_arqos,
  output logic [3:0]                  axi4m_arregion,
  output logic                        axi4m_arvalid,
  input  logic                        axi4m_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi4m_rdata,
  input  logic [1:0]                  axi4m_rresp,
  input  logic                        axi4m_rlast,
  input  logic                        axi4m_rvalid,
  output logic                        axi4m_rready
);

  localparam int BYTES   = AXI_DATA_WIDTH / 8;
  localparam int SIZE    = $clog2(BYTES);
  localparam int FIX_MAX = (MAX_BURST < 16) ? MAX_BURST : 16;
  localparam int CLW     = CMD_LEN_WIDTH;
  localparam int AW      = AXI_ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_ADDR, S_WDATA, S_BRESP, S_RDATA, S_NEXT, S_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CLW-1:0]   rem_q, rem_d;
  logic [8:0]       beats_q, beats_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [1:0]       resp_q, resp_d;
  logic             rnw_q, rnw_d;
  logic             burst_q, burst_d;
  logic             mis_q, mis_d;

  logic             cmd_hs, w_hs, r_hs, last_beat;
  logic [12:0]      to4k;
  logic [8:0]       cap, b_calc;

  assign cmd_hs    = cmd_valid && cmd_ready;
  assign w_hs      = axi4m_wvalid && axi4m_wready;
  assign r_hs      = axi4m_rvalid && axi4m_rready;
  assign last_beat = (cnt_q == beats_q - 9'd1);

  // Burst size: remaining beats, clipped by the 4 KB page (INCR only) and the burst-type cap.
  always_comb begin
    to4k = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE;
    cap  = 9'(FIX_MAX);
    if (burst_q) cap = (to4k < 13'(MAX_BURST)) ? to4k[8:0] : 9'(MAX_BURST);
    b_calc = (rem_q < CLW'(cap)) ? rem_q[8:0] : cap;
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    beats_d = beats_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    rnw_d   = rnw_q;
    burst_d = burst_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: if (cmd_hs) begin
        addr_d  = cmd_addr;
        rem_d   = (cmd_len == '0) ? CLW'(1) : cmd_len;
        rnw_d   = cmd_rnw;
        burst_d = cmd_burst;
        mis_d   = |cmd_addr[SIZE-1:0];
        resp_d  = 2'b00;
        cnt_d   = 9'd0;
        state_d = S_CALC;
      end
      S_CALC: begin
        beats_d = b_calc;
        cnt_d   = 9'd0;
        state_d = mis_q ? S_FIN : S_ADDR;
      end
      S_ADDR: if (rnw_q ? axi4m_arready : axi4m_awready)
        state_d = rnw_q ? S_RDATA : S_WDATA;
      S_WDATA: if (w_hs) begin
        cnt_d = cnt_q + 9'd1;
        if (last_beat) state_d = S_BRESP;
      end
      S_BRESP: if (axi4m_bvalid) begin
        if (axi4m_bresp > resp_q) resp_d = axi4m_bresp;
        state_d = S_NEXT;
      end
      S_RDATA: if (r_hs) begin
        if (axi4m_rresp > resp_q) resp_d = axi4m_rresp;
        if (axi4m_rlast) state_d = S_NEXT;
      end
      S_NEXT: begin
        rem_d = rem_q - CLW'(beats_q);
        if (burst_q) addr_d = addr_q + (AW'(beats_q) << SIZE);
        state_d = (rem_q == CLW'(beats_q)) ? S_FIN : S_CALC;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beats_q <= '0;
      cnt_q   <= '0;
      resp_q  <= '0;
      rnw_q   <= 1'b0;
      burst_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beats_q <= beats_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rnw_q   <= rnw_d;
      burst_q <= burst_d;
      mis_q   <= mis_d;
    end
  end

  // cmd_ready is masked by reset so the command port is closed while aresetn is low.
  assign cmd_ready     = aresetn && (state_q == S_IDLE);
  assign done          = (state_q == S_FIN);
  assign done_resp     = resp_q;
  assign done_misalign = (state_q == S_FIN) && mis_q;

  assign axi4m_awid     = '0;
  assign axi4m_awaddr   = addr_q;
  assign axi4m_awlen    = 8'(beats_q - 9'd1);
  assign axi4m_awsize   = 3'(SIZE);
  assign axi4m_awburst  = {1'b0, burst_q};
  assign axi4m_awlock   = 1'b0;
  assign axi4m_awcache  = 4'b0011;
  assign axi4m_awprot   = 3'b000;
  assign axi4m_awqos    = 4'b0000;
  assign axi4m_awregion = 4'b0000;
  assign axi4m_awvalid  = (state_q == S_ADDR) && !rnw_q;

  assign axi4m_arid     = '0;
  assign axi4m_araddr   = addr_q;
  assign axi4m_arlen    = 8'(beats_q - 9'd1);
  assign axi4m_arsize   = 3'(SIZE);
  assign axi4m_arburst  = {1'b0, burst_q};
  assign axi4m_arlock   = 1'b0;
  assign axi4m_arcache  = 4'b0011;
  assign axi4m_arprot   = 3'b000;
  assign axi4m_arqos    = 4'b0000;
  assign axi4m_arregion = 4'b0000;
  assign axi4m_arvalid  = (state_q == S_ADDR) && rnw_q;

  assign axi4m_wdata  = wr_tdata;
  assign axi4m_wstrb  = '1;
  assign axi4m_wvalid = (state_q == S_WDATA) && wr_tvalid;
  assign axi4m_wlast  = (state_q == S_WDATA) && last_beat;
  assign wr_tready    = (state_q == S_WDATA) && axi4m_wready;
  assign axi4m_bready = (state_q == S_BRESP);

  // Read data is a pure pass-through; tlast only on the final burst of the command.
  assign rd_tdata     = axi4m_rdata;
  assign rd_tvalid    = (state_q == S_RDATA) && axi4m_rvalid;
  assign axi4m_rready = (state_q == S_RDATA) && rd_tready;
  assign rd_tlast     = (state_q == S_RDATA) && axi4m_rlast && (rem_q == CLW'(beats_q));

`ifdef AXI4_BURST_MASTER_PERF_EN
  logic [31:0] perf_beats_q, perf_cycles_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_beats_q  <= '0;
      perf_cycles_q <= '0;
    end else if (cmd_hs) begin
      perf_beats_q  <= '0;
      perf_cycles_q <= '0;
    end else if (state_q != S_IDLE) begin
      perf_cycles_q <= perf_cycles_q + 32'd1;
      if (w_hs || r_hs) perf_beats_q <= perf_beats_q + 32'd1;
    end
  end

  assign perf_beats  = perf_beats_q;
  assign perf_cycles = perf_cycles_q;
`endif

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master: a small AXI4 slave and stream model driven cycle by cycle from one process.
module tb_axi4_burst_master;
  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_rnw, cmd_burst;
  logic [31:0] cmd_addr;
  logic [23:0] cmd_len;
  logic [31:0] wr_tdata, rd_tdata;
  logic        wr_tvalid, wr_tready, rd_tvalid, rd_tready, rd_tlast;
  logic        done, done_misalign;
  logic [1:0]  done_resp;
  logic [0:0]  axi4m_awid, axi4m_arid;
  logic [31:0] axi4m_awaddr, axi4m_araddr, axi4m_wdata, axi4m_rdata;
  logic [7:0]  axi4m_awlen, axi4m_arlen;
  logic [2:0]  axi4m_awsize, axi4m_arsize, axi4m_awprot, axi4m_arprot;
  logic [1:0]  axi4m_awburst, axi4m_arburst, axi4m_bresp, axi4m_rresp;
  logic        axi4m_awlock, axi4m_arlock;
  logic [3:0]  axi4m_awcache, axi4m_arcache, axi4m_awqos, axi4m_arqos, axi4m_awregion, axi4m_arregion;
  logic        axi4m_awvalid, axi4m_awready, axi4m_arvalid, axi4m_arready;
  logic [3:0]  axi4m_wstrb;
  logic        axi4m_wlast, axi4m_wvalid, axi4m_wready, axi4m_bvalid, axi4m_bready;
  logic        axi4m_rlast, axi4m_rvalid, axi4m_rready;
`ifdef AXI4_BURST_MASTER_PERF_EN
  logic [31:0] perf_beats, perf_cycles;
`endif

  always #5 aclk = ~aclk;

  axi4_burst_master dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_burst(cmd_burst),
    .wr_tdata(wr_tdata), .wr_tvalid(wr_tvalid), .wr_tready(wr_tready),
    .rd_tdata(rd_tdata), .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .rd_tlast(rd_tlast),
    .done(done), .done_resp(done_resp), .done_misalign(done_misalign),
`ifdef AXI4_BURST_MASTER_PERF_EN
    .perf_beats(perf_beats), .perf_cycles(perf_cycles),
`endif
    .axi4m_awid(axi4m_awid), .axi4m_awaddr(axi4m_awaddr), .axi4m_awlen(axi4m_awlen),
    .axi4m_awsize(axi4m_awsize), .axi4m_awburst(axi4m_awburst), .axi4m_awlock(axi4m_awlock),
    .axi4m_awcache(axi4m_awcache), .axi4m_awprot(axi4m_awprot), .axi4m_awqos(axi4m_awqos),
    .axi4m_awregion(axi4m_awregion), .axi4m_awvalid(axi4m_awvalid), .axi4m_awready(axi4m_awready),
    .axi4m_wdata(axi4m_wdata), .axi4m_wstrb(axi4m_wstrb), .axi4m_wlast(axi4m_wlast),
    .axi4m_wvalid(axi4m_wvalid), .axi4m_wready(axi4m_wready),
    .axi4m_bresp(axi4m_bresp), .axi4m_bvalid(axi4m_bvalid), .axi4m_bready(axi4m_bready),
    .axi4m_arid(axi4m_arid), .axi4m_araddr(axi4m_araddr), .axi4m_arlen(axi4m_arlen),
    .axi4m_arsize(axi4m_arsize), .axi4m_arburst(axi4m_arburst), .axi4m_arlock(axi4m_arlock),
    .axi4m_arcache(axi4m_arcache), .axi4m_arprot(axi4m_arprot), .axi4m_arqos(axi4m_arqos),
    .axi4m_arregion(axi4m_arregion), .axi4m_arvalid(axi4m_arvalid), .axi4m_arready(axi4m_arready),
    .axi4m_rdata(axi4m_rdata), .axi4m_rresp(axi4m_rresp), .axi4m_rlast(axi4m_rlast),
    .axi4m_rvalid(axi4m_rvalid), .axi4m_rready(axi4m_rready)
  );

  int vecs, errs, cyc;
  int wr_total, wr_sent, b_idx, err_burst, r_left, r_tot, r_err_beat;
  logic b_pend, wr_stall, rd_stall;
  logic hs_aw, hs_w, hs_b, hs_ar, hs_r, wlast_s, cmd_hs_s;
  logic [7:0] arlen_s;
  logic [31:0] aw_addr_l [0:15];
  logic [7:0]  aw_len_l  [0:15];
  logic [1:0]  aw_bst_l  [0:15];
  logic [31:0] ar_addr_l [0:15];
  logic [7:0]  ar_len_l  [0:15];
  logic [1:0]  ar_bst_l  [0:15];
  logic [32:0] w_l [0:511];
  logic [32:0] r_l [0:511];
  int n_aw, n_ar, n_w, n_r, done_cnt, done_cyc, cmd_cyc, ax_cyc, overlap, strb_bad;
  logic [1:0] done_resp_s;
  logic done_mis_s;

  task automatic drive();
    wr_tvalid     = (wr_sent < wr_total) && !(wr_stall && (cyc % 3 == 0));
    wr_tdata      = 32'hA000_0000 + 32'(wr_sent);
    axi4m_awready = 1'b1;
    axi4m_arready = 1'b1;
    axi4m_wready  = 1'b1;
    axi4m_bvalid  = b_pend;
    axi4m_bresp   = (b_idx == err_burst) ? 2'b10 : 2'b00;
    axi4m_rvalid  = (r_left > 0);
    axi4m_rdata   = 32'hC000_0000 + 32'(r_tot);
    axi4m_rlast   = (r_left == 1);
    axi4m_rresp   = (r_tot == r_err_beat) ? 2'b01 : 2'b00;
    rd_tready     = !(rd_stall && (cyc % 4 == 1));
  endtask

  task automatic clear_model();
    wr_total = 0; wr_sent = 0; b_idx = 0; err_burst = -1; r_left = 0; r_tot = 0; r_err_beat = -1;
    b_pend = 1'b0; wr_stall = 1'b0; rd_stall = 1'b0;
    n_aw = 0; n_ar = 0; n_w = 0; n_r = 0; done_cnt = 0; done_cyc = -1; cmd_cyc = -1; ax_cyc = -1;
    overlap = 0; strb_bad = 0; done_resp_s = 2'b00; done_mis_s = 1'b0;
    drive();
  endtask

  // One clock: sample what the coming posedge will see, then update the slave model at the negedge.
  task automatic step();
    hs_aw = axi4m_awvalid && axi4m_awready;
    hs_w  = axi4m_wvalid && axi4m_wready;
    hs_b  = axi4m_bvalid && axi4m_bready;
    hs_ar = axi4m_arvalid && axi4m_arready;
    hs_r  = rd_tvalid && rd_tready;
    wlast_s = axi4m_wlast;
    arlen_s = axi4m_arlen;
    cmd_hs_s = cmd_valid && cmd_ready;
    if (cmd_hs_s) cmd_cyc = cyc;
    if ((axi4m_awvalid || axi4m_arvalid) && ax_cyc < 0) ax_cyc = cyc;
    if (axi4m_awvalid && axi4m_wvalid) overlap++;
    if (hs_aw && n_aw < 16) begin
      aw_addr_l[n_aw] = axi4m_awaddr; aw_len_l[n_aw] = axi4m_awlen; aw_bst_l[n_aw] = axi4m_awburst; n_aw++;
    end
    if (hs_ar && n_ar < 16) begin
      ar_addr_l[n_ar] = axi4m_araddr; ar_len_l[n_ar] = axi4m_arlen; ar_bst_l[n_ar] = axi4m_arburst; n_ar++;
    end
    if (hs_w && n_w < 512) begin
      w_l[n_w] = {axi4m_wlast, axi4m_wdata}; n_w++;
      if (axi4m_wstrb !== 4'hF) strb_bad++;
    end
    if (hs_r && n_r < 512) begin r_l[n_r] = {rd_tlast, rd_tdata}; n_r++; end
    if (done) begin done_cnt++; done_cyc = cyc; done_resp_s = done_resp; done_mis_s = done_misalign; end
    @(negedge aclk);
    cyc++;
    if (cmd_hs_s) cmd_valid = 1'b0;
    if (hs_w) wr_sent++;
    if (hs_w && wlast_s) b_pend = 1'b1;
    if (hs_b) begin b_pend = 1'b0; b_idx++; end
    if (hs_ar) r_left = int'(arlen_s) + 1;
    if (hs_r) begin r_left--; r_tot++; end
    drive();
    #1;
  endtask

  task automatic run_cmd(input logic rnw, input logic [31:0] addr, input logic [23:0] len, input logic bst);
    cmd_rnw = rnw; cmd_addr = addr; cmd_len = len; cmd_burst = bst; cmd_valid = 1'b1;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
    for (int i = 0; i < 4; i++) step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    vecs++;
    if ({cmd_ready, axi4m_awvalid, axi4m_arvalid, axi4m_wvalid, done} !== 5'b0) begin
      errs++; $display("FAIL reset_hold: got %b expected 00000", {cmd_ready, axi4m_awvalid, axi4m_arvalid, axi4m_wvalid, done});
    end
    @(negedge aclk); aresetn = 1'b1; #1;
    vecs++;
    if ({cmd_ready, done, done_resp, done_misalign, axi4m_bready, axi4m_rready} !== 7'b1000000) begin
      errs++; $display("FAIL reset_release: got %b expected 1000000", {cmd_ready, done, done_resp, done_misalign, axi4m_bready, axi4m_rready});
    end
    vecs++;
    if ({axi4m_awsize, axi4m_awcache, axi4m_arcache} !== {3'd2, 4'b0011, 4'b0011}) begin
      errs++; $display("FAIL const_fields: got %h expected %h", {axi4m_awsize, axi4m_awcache, axi4m_arcache}, {3'd2, 4'b0011, 4'b0011});
    end
  endtask

  task automatic test_incr_4k_write();
    clear_model(); wr_total = 10;
    run_cmd(1'b0, 32'h0000_0FF0, 24'd10, 1'b1);
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL incr_done_count: got %0d expected 1", done_cnt); end
    vecs++; if (ax_cyc - cmd_cyc !== 2) begin errs++; $display("FAIL incr_aw_latency: got %0d expected 2", ax_cyc - cmd_cyc); end
    vecs++; if (n_aw !== 2) begin errs++; $display("FAIL incr_aw_count: got %0d expected 2", n_aw); end
    vecs++;
    if ({aw_addr_l[0], aw_len_l[0], aw_bst_l[0]} !== {32'h0FF0, 8'd3, 2'b01}) begin
      errs++; $display("FAIL incr_aw0: got %h/%0d/%b expected 0ff0/3/01", aw_addr_l[0], aw_len_l[0], aw_bst_l[0]);
    end
    vecs++;
    if ({aw_addr_l[1], aw_len_l[1], aw_bst_l[1]} !== {32'h1000, 8'd5, 2'b01}) begin
      errs++; $display("FAIL incr_aw1: got %h/%0d/%b expected 1000/5/01", aw_addr_l[1], aw_len_l[1], aw_bst_l[1]);
    end
    vecs++; if (n_w !== 10) begin errs++; $display("FAIL incr_w_count: got %0d expected 10", n_w); end
    for (int i = 0; i < 10 && i < n_w; i++) begin
      vecs++;
      if (w_l[i] !== {(i == 3 || i == 9), 32'hA000_0000 + 32'(i)}) begin
        errs++; $display("FAIL incr_wbeat%0d: got %h expected %h", i, w_l[i], {(i == 3 || i == 9), 32'hA000_0000 + 32'(i)});
      end
    end
    vecs++;
    if ({done_resp_s, done_mis_s, overlap != 0, strb_bad != 0} !== 5'b0) begin
      errs++; $display("FAIL incr_status: got resp=%0d mis=%0b overlap=%0d strb=%0d expected 0/0/0/0", done_resp_s, done_mis_s, overlap, strb_bad);
    end
  endtask

  task automatic test_read_split();
    clear_model(); rd_stall = 1'b1;
    run_cmd(1'b1, 32'h0, 24'd300, 1'b1);
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL rd_done_count: got %0d expected 1", done_cnt); end
    vecs++; if (ax_cyc - cmd_cyc !== 2) begin errs++; $display("FAIL rd_ar_latency: got %0d expected 2", ax_cyc - cmd_cyc); end
    vecs++; if ({n_ar, n_aw} !== {32'd2, 32'd0}) begin errs++; $display("FAIL rd_ax_count: got ar=%0d aw=%0d expected 2/0", n_ar, n_aw); end
    vecs++;
    if ({ar_addr_l[0], ar_len_l[0], ar_bst_l[0], ar_addr_l[1], ar_len_l[1], ar_bst_l[1]} !==
        {32'h0, 8'd255, 2'b01, 32'h400, 8'd43, 2'b01}) begin
      errs++; $display("FAIL rd_ar_fields: got %h/%0d %h/%0d expected 0/255 400/43", ar_addr_l[0], ar_len_l[0], ar_addr_l[1], ar_len_l[1]);
    end
    vecs++; if (n_r !== 300) begin errs++; $display("FAIL rd_beat_count: got %0d expected 300", n_r); end
    for (int i = 0; i < 300 && i < n_r; i++) begin
      vecs++;
      if (r_l[i] !== {(i == 299), 32'hC000_0000 + 32'(i)}) begin
        errs++; $display("FAIL rd_beat%0d: got %h expected %h", i, r_l[i], {(i == 299), 32'hC000_0000 + 32'(i)});
      end
    end
    vecs++; if (done_resp_s !== 2'b00) begin errs++; $display("FAIL rd_resp: got %0d expected 0", done_resp_s); end
  endtask

  task automatic test_read_4k_rresp();
    clear_model(); r_err_beat = 1;
    run_cmd(1'b1, 32'h0000_0FF8, 24'd4, 1'b1);
    vecs++;
    if ({n_ar, ar_addr_l[0], ar_len_l[0], ar_addr_l[1], ar_len_l[1]} !== {32'd2, 32'hFF8, 8'd1, 32'h1000, 8'd1}) begin
      errs++; $display("FAIL rd4k_ar: got n=%0d %h/%0d %h/%0d expected 2 ff8/1 1000/1", n_ar, ar_addr_l[0], ar_len_l[0], ar_addr_l[1], ar_len_l[1]);
    end
    vecs++;
    if ({r_l[0][32], r_l[1][32], r_l[2][32], r_l[3][32]} !== 4'b0001) begin
      errs++; $display("FAIL rd4k_tlast: got %b expected 0001", {r_l[0][32], r_l[1][32], r_l[2][32], r_l[3][32]});
    end
    vecs++; if (done_resp_s !== 2'b01) begin errs++; $display("FAIL rd4k_resp: got %0d expected 1", done_resp_s); end
  endtask

  task automatic test_fixed_write();
    clear_model(); wr_total = 40; wr_stall = 1'b1;
    run_cmd(1'b0, 32'h40, 24'd40, 1'b0);
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL fix_done_count: got %0d expected 1", done_cnt); end
    vecs++; if (n_aw !== 3) begin errs++; $display("FAIL fix_aw_count: got %0d expected 3", n_aw); end
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if ({aw_addr_l[k], aw_len_l[k], aw_bst_l[k]} !== {32'h40, (k == 2) ? 8'd7 : 8'd15, 2'b00}) begin
        errs++; $display("FAIL fix_aw%0d: got %h/%0d/%b expected 40/%0d/00", k, aw_addr_l[k], aw_len_l[k], aw_bst_l[k], (k == 2) ? 7 : 15);
      end
    end
    vecs++; if (n_w !== 40) begin errs++; $display("FAIL fix_w_count: got %0d expected 40", n_w); end
    for (int i = 0; i < 40 && i < n_w; i++) begin
      vecs++;
      if (w_l[i] !== {(i == 15 || i == 31 || i == 39), 32'hA000_0000 + 32'(i)}) begin
        errs++; $display("FAIL fix_wbeat%0d: got %h expected %h", i, w_l[i], {(i == 15 || i == 31 || i == 39), 32'hA000_0000 + 32'(i)});
      end
    end
    vecs++; if (overlap !== 0) begin errs++; $display("FAIL fix_aw_w_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_error_resp();
    clear_model(); wr_total = 20; err_burst = 1;
    run_cmd(1'b0, 32'h100, 24'd20, 1'b0);
    vecs++; if (done_cnt !== 1) begin errs++; $display("FAIL err_done_count: got %0d expected 1", done_cnt); end
    vecs++; if ({n_aw, aw_len_l[0], aw_len_l[1]} !== {32'd2, 8'd15, 8'd3}) begin
      errs++; $display("FAIL err_aw: got n=%0d len %0d/%0d expected 2 15/3", n_aw, aw_len_l[0], aw_len_l[1]);
    end
    vecs++; if (n_w !== 20) begin errs++; $display("FAIL err_w_count: got %0d expected 20", n_w); end
    vecs++; if (done_resp_s !== 2'b10) begin errs++; $display("FAIL err_done_resp: got %0d expected 2", done_resp_s); end
  endtask

  task automatic test_misalign();
    clear_model(); wr_total = 4;
    run_cmd(1'b0, 32'h2, 24'd4, 1'b1);
    vecs++; if ({done_cnt, done_mis_s} !== {32'd1, 1'b1}) begin
      errs++; $display("FAIL mis_done: got cnt=%0d mis=%0b expected 1/1", done_cnt, done_mis_s);
    end
    vecs++; if (done_cyc - cmd_cyc !== 2) begin errs++; $display("FAIL mis_latency: got %0d expected 2", done_cyc - cmd_cyc); end
    vecs++; if ({n_aw, n_ar, n_w} !== {32'd0, 32'd0, 32'd0}) begin
      errs++; $display("FAIL mis_no_traffic: got aw=%0d ar=%0d w=%0d expected 0/0/0", n_aw, n_ar, n_w);
    end
  endtask

  task automatic test_reset_mid_burst();
    clear_model(); wr_total = 16;
    cmd_rnw = 1'b0; cmd_addr = 32'h0; cmd_len = 24'd16; cmd_burst = 1'b1; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && n_w < 4; i++) step();
    vecs++; if (axi4m_wvalid !== 1'b1) begin errs++; $display("FAIL rst_mid_beat5_pending: got %0b expected 1", axi4m_wvalid); end
    aresetn = 1'b0; #1;
    vecs++;
    if ({axi4m_awvalid, axi4m_wvalid, axi4m_arvalid, done, cmd_ready} !== 5'b0) begin
      errs++; $display("FAIL rst_mid_drop: got %b expected 00000", {axi4m_awvalid, axi4m_wvalid, axi4m_arvalid, done, cmd_ready});
    end
    clear_model();
    @(negedge aclk); @(negedge aclk); aresetn = 1'b1; #1;
    vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_mid_ready: got %0b expected 1", cmd_ready); end
    for (int i = 0; i < 6; i++) step();
    vecs++; if ({done_cnt, n_aw, n_w} !== {32'd0, 32'd0, 32'd0}) begin
      errs++; $display("FAIL rst_mid_stale: got done=%0d aw=%0d w=%0d expected 0/0/0", done_cnt, n_aw, n_w);
    end
  endtask

  task automatic test_back_to_back();
    clear_model(); wr_total = 3;
    run_cmd(1'b0, 32'h200, 24'd0, 1'b1);
    vecs++; if ({n_aw, aw_len_l[0], n_w} !== {32'd1, 8'd0, 32'd1}) begin
      errs++; $display("FAIL b2b_len0: got aw=%0d len=%0d w=%0d expected 1/0/1", n_aw, aw_len_l[0], n_w);
    end
    clear_model();
    run_cmd(1'b1, 32'h300, 24'd2, 1'b0);
    vecs++; if ({n_ar, ar_len_l[0], ar_bst_l[0], n_r} !== {32'd1, 8'd1, 2'b00, 32'd2}) begin
      errs++; $display("FAIL b2b_read: got ar=%0d len=%0d bst=%b r=%0d expected 1/1/00/2", n_ar, ar_len_l[0], ar_bst_l[0], n_r);
    end
  endtask

  initial begin
    vecs = 0; errs = 0; cyc = 0;
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_burst = 1'b0;
    clear_model();
    repeat (3) @(negedge aclk);
    #1;
    test_reset();
    test_incr_4k_write();
    test_read_split();
    test_read_4k_rresp();
    test_fixed_write();
    test_error_resp();
    test_misalign();
    test_reset_mid_burst();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
